// File: rtl/decode_stage.sv
// decode_stage: ARM-subset decode with RAW scoreboard; optional DECODE_WB_BYPASS_EN lets a retiring writeback satisfy a stalled read
module decode_stage #(
  parameter int NUM_REGS = 16
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] instr_pc_i,
  input  logic        instr_valid_i,
  output logic        instr_ready_o,
  input  logic        flush_i,
  output logic [3:0]  r1_addr_o,
  output logic [3:0]  r2_addr_o,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [3:0]  cond_o,
  output logic [1:0]  class_o,
  output logic [3:0]  opcode_o,
  output logic        imm_flag_o,
  output logic        set_flags_o,
  output logic [3:0]  rd_o,
  output logic        wr_en_o,
  output logic [23:0] imm_o,
  output logic [31:0] pc_o,
  input  logic        wb_valid_i,
  input  logic [3:0]  wb_addr_i
);
  logic [NUM_REGS-1:0] r_sb;
  logic [NUM_REGS-1:0] w_set, w_clr, w_sb_eff;
  logic [1:0] w_cls_in, w_cls;
  logic [3:0] w_op, w_rn, w_rd, w_rm;
  logic       w_i, w_l, w_held, w_u1, w_u2, w_we, w_haz, w_acc;
  // Decode fields come from the held instruction while execute stalls, so register_file keeps reading its sources
  always_comb begin
    w_held   = valid_o && !ready_i;
    w_cls_in = instr_i[27:26] == 2'b00 ? 2'b00 :
               instr_i[27:26] == 2'b01 ? 2'b01 :
               instr_i[27:25] == 3'b101 ? 2'b10 : 2'b11;
    w_cls    = w_held ? class_o     : w_cls_in;
    w_op     = w_held ? opcode_o    : instr_i[24:21];
    w_i      = w_held ? imm_flag_o  : instr_i[25];
    w_l      = w_held ? set_flags_o : instr_i[20];
    w_rn     = w_held ? imm_o[19:16] : instr_i[19:16];
    w_rd     = w_held ? rd_o        : instr_i[15:12];
    w_rm     = w_held ? imm_o[3:0]  : instr_i[3:0];
    w_u1     = (w_cls == 2'b00 && w_op != 4'b1101 && w_op != 4'b1111) || w_cls == 2'b01;
    w_u2     = (w_cls == 2'b00 && !w_i) || (w_cls == 2'b01 && !w_l);
    w_we     = (w_cls == 2'b00 && w_op[3:2] != 2'b10) || (w_cls == 2'b01 && w_l);
    r1_addr_o = w_u1 ? w_rn : 4'd0;
    r2_addr_o = !w_u2 ? 4'd0 : (w_cls == 2'b01 ? w_rd : w_rm);
  end
  assign w_clr = (wb_valid_i && wb_addr_i != 4'd15) ? NUM_REGS'(1) << wb_addr_i : '0;
  assign w_set = (valid_o && ready_i && !flush_i && wr_en_o && rd_o != 4'd15) ? NUM_REGS'(1) << rd_o : '0;
`ifdef DECODE_WB_BYPASS_EN
  assign w_sb_eff = r_sb & ~w_clr;
`else
  assign w_sb_eff = r_sb;
`endif
  // A source is busy if marked pending or written by the instruction currently in the output register; r15 never stalls
  always_comb begin
    w_haz = (w_u1 && r1_addr_o != 4'd15 && (w_sb_eff[r1_addr_o] || (valid_o && wr_en_o && rd_o == r1_addr_o))) ||
            (w_u2 && r2_addr_o != 4'd15 && (w_sb_eff[r2_addr_o] || (valid_o && wr_en_o && rd_o == r2_addr_o)));
    instr_ready_o = !reset_i && !flush_i && !w_haz && (!valid_o || ready_i);
    w_acc = instr_valid_i && instr_ready_o;
  end
  // Output register: flush kills, accept loads, handoff empties, otherwise hold
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      valid_o     <= 1'b0;
      cond_o      <= '0;
      class_o     <= '0;
      opcode_o    <= '0;
      imm_flag_o  <= 1'b0;
      set_flags_o <= 1'b0;
      rd_o        <= '0;
      wr_en_o     <= 1'b0;
      imm_o       <= '0;
      pc_o        <= '0;
    end else if (flush_i) begin
      valid_o <= 1'b0;
    end else if (w_acc) begin
      valid_o     <= 1'b1;
      cond_o      <= instr_i[31:28];
      class_o     <= w_cls_in;
      opcode_o    <= instr_i[24:21];
      imm_flag_o  <= instr_i[25];
      set_flags_o <= instr_i[20];
      rd_o        <= instr_i[15:12];
      wr_en_o     <= w_we;
      imm_o       <= instr_i[23:0];
      pc_o        <= instr_pc_i;
    end else if (ready_i) begin
      valid_o <= 1'b0;
    end
  end
  // Pending-write scoreboard; a new writer's set beats a same-cycle writeback clear
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) r_sb <= '0;
    else         r_sb <= (r_sb & ~w_clr) | w_set;
  end
endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Instruction decode stage that sits directly upstream of register_file and downstream of fetch.
- Extracts source register addresses from the incoming 32-bit ARM-subset instruction and drives them to register_file.
- Registers the decoded control fields one cycle later, aligned with register_file's registered r1_o/r2_o.
- Holds a 16-entry pending-write scoreboard and stalls fetch on RAW hazards.

Parameters:
- NUM_REGS, 16, number of architectural registers tracked by the scoreboard (r15 = pc, never tracked).

Ports:
- clk_i  input  1  clock, all state on rising edge
- reset_i  input  1  asynchronous, active-high reset
- instr_i  input  32  instruction from fetch
- instr_pc_i  input  32  pc of instr_i
- instr_valid_i  input  1  instr_i valid
- instr_ready_o  output  1  decode accepts instr_i this cycle
- flush_i  input  1  kill decode output (branch taken downstream)
- r1_addr_o  output  4  to register_file r1_addr_i
- r2_addr_o  output  4  to register_file r2_addr_i
- valid_o  output  1  decoded instruction valid
- ready_i  input  1  execute accepts decoded instruction
- cond_o  output  4  instr[31:28]
- class_o  output  2  00 data-proc, 01 load/store, 10 branch, 11 undefined
- opcode_o  output  4  instr[24:21]
- imm_flag_o  output  1  instr[25]
- set_flags_o  output  1  instr[20] (S bit, or L bit for load/store)
- rd_o  output  4  destination register instr[15:12]
- wr_en_o  output  1  instruction writes rd_o
- imm_o  output  24  instr[23:0] raw (branch offset / immediate field)
- pc_o  output  32  pc of decoded instruction
- wb_valid_i  input  1  writeback retiring a register write
- wb_addr_i  input  4  register being written back

Behaviour:
- Reset (async, reset_i=1): valid_o=0, scoreboard=0, all registered outputs 0, instr_ready_o=0 while reset is asserted.
- Classification:
  - instr[27:26]=00 → data-proc.
  - 01 → load/store.
  - instr[27:25]=101 → branch.
  - Anything else → undefined (wr_en_o=0, no sources).
- Sources:
  - Data-proc: src1=Rn[19:16]; src2=Rm[3:0] only if imm_flag=0. MOV/MVN (opcode 1101/1111) have no src1.
  - Load/store: src1=Rn; src2=Rd only for store (L=0).
  - Branch: no sources.
  - Unused source address drives 0.
- wr_en: data-proc except TST/TEQ/CMP/CMN (opcode 10xx); load (L=1). Never for store, branch, or undefined.
- Address mux (combinational): if valid_o && !ready_i (held), r1/r2_addr_o = sources of the held instruction; else sources of instr_i. This keeps register_file's registered outputs aligned with the held instruction.
- Hazard:
  - A used source s ≠ 15 with (scoreboard[s]=1) or (valid_o && wr_en_o && rd_o==s) → hazard.
  - r15 sources never hazard.
- instr_ready_o = !reset_i && !flush_i && !hazard && (!valid_o || ready_i).
- Accept (instr_valid_i && instr_ready_o): on the next edge, load all outputs from instr_i and set valid_o=1. Latency is 1 cycle from accept to valid_o, the same edge register_file presents r1_o/r2_o.
- Handoff (valid_o && ready_i) without a new accept → valid_o=0 next edge.
- Held (valid_o && !ready_i): all outputs stable.
- Flush: flush_i=1 → valid_o=0 next edge, nothing accepted that cycle. Flush overrides handoff; no scoreboard set for the flushed instruction.
- Scoreboard set: on handoff with wr_en_o=1 and rd_o≠15 → bit rd_o set.
- Scoreboard clear: wb_valid_i → bit wb_addr_i cleared.
- Same-cycle set and clear of the same bit → set wins (newer writer).
- wb_addr_i=15 is ignored.

Optional Feature:
- Macro DECODE_WB_BYPASS_EN.
- Defined: a source whose scoreboard bit is being cleared this cycle by wb_valid_i/wb_addr_i does not count as hazard. This removes 1 stall cycle; it relies on register_file's write-before-read on the same edge.
- Undefined: scoreboard bits only are checked, so the stall lasts until the cycle after writeback.

Test Plan:
- Reset mid-stream: valid_o=1 holding ADD, assert reset_i asynchronously → valid_o=0 and scoreboard=0 immediately, without waiting for a clock edge.
- ADD r3,r1,r2 (0xE0813002), valid with ready_i=1 → r1_addr_o=1, r2_addr_o=2 in accept cycle; next cycle valid_o=1, rd_o=3, wr_en_o=1, class_o=00.
- RAW hazard: ADD r3,r1,r2 then SUB r4,r3,r1 (0xE0434001) back-to-back → instr_ready_o=0 until wb_valid_i with wb_addr_i=3. Without bypass, accept occurs the cycle after wb; with DECODE_WB_BYPASS_EN, accept occurs in the wb cycle.
- Backpressure: ready_i=0 for 3 cycles with LDR r5,[r2] held → r1_addr_o=2 and all outputs stable; instr_ready_o=0; release → next instruction accepted.
- Flush: flush_i=1 while valid_o=1 (CMP r1,r2) and instr_valid_i=1 → next cycle valid_o=0, instruction not accepted, scoreboard unchanged.
- r15 source: ADD r0,r15,#4 with scoreboard all 1s → no stall, r1_addr_o=15, imm_flag_o=1.
